writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: accepts the registered write-back bundle (data, destination register, write-enable) and commits it into the architectural register file.
- Provides two combinational read ports to the decode stage.
- Maintains a pending-write scoreboard so decode can detect RAW hazards on in-flight destinations.
- Maintains a retired-write counter for performance monitoring.

Parameters:
- DATA_W, 32: register width.
- ADDR_W, 5: register index width; depth = 2**ADDR_W.
- CNT_W, 32: retired-write counter width.

Ports:
- i_clk  input  1  sole clock, rising edge.
- i_rst  input  1  reset. One clock; reset is synchronous and active-high.
- i_WB  input  1  write-back enable from MEM/WB.
- i_Rw  input  ADDR_W  write-back destination index.
- i_data  input  DATA_W  write-back data.
- i_Ra  input  ADDR_W  read port A index.
- i_Rb  input  ADDR_W  read port B index.
- o_busA  output  DATA_W  read port A data.
- o_busB  output  DATA_W  read port B data.
- i_issue  input  1  decode issues an instruction that will write i_issue_Rw.
- i_issue_Rw  input  ADDR_W  destination of the issued instruction.
- o_busy_a  output  1  register i_Ra has an outstanding write.
- o_busy_b  output  1  register i_Rb has an outstanding write.
- o_wb_count  output  CNT_W  number of retired non-zero-destination writes.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - all registers, all pending bits and o_wb_count cleared to 0.
  - o_busA/o_busB therefore read 0 and o_busy_a/o_busy_b read 0 on the next cycle.
  - Reset overrides any i_WB/i_issue in the same cycle.
  - Reset mid-operation discards all outstanding pending bits.
- Write:
  - at a rising edge with i_WB=1 and i_Rw!=0, reg[i_Rw] <= i_data.
  - i_WB=1 with i_Rw=0 is a no-op: no write, no count, no scoreboard change.
- Register 0: hardwired to 0; reads always return 0 and its pending bit is never set.
- Reads: combinational, zero latency; o_busA = reg[i_Ra], o_busB = reg[i_Rb] (subject to bypass, see Optional Feature).
- Scoreboard (one pending bit per register):
  - Issue with i_issue=1 and i_issue_Rw!=0 sets pending[i_issue_Rw] at the edge.
  - Write-back with i_WB=1 and i_Rw!=0 clears pending[i_Rw] at the edge.
  - If set and clear target the same register in the same cycle, set wins, because the newer instruction is still in flight.
  - Set and clear on different registers both take effect.
  - Issue to a register already pending keeps it pending; the scoreboard is not a counter, so decode must stall WAW itself.
  - Write-back to a non-pending register is legal and leaves the bit at 0.
- Busy outputs: o_busy_a = pending[i_Ra] and o_busy_b = pending[i_Rb], combinational; both are 0 when the index is 0.
- Counter:
  - o_wb_count increments by 1 at every edge with i_WB=1 and i_Rw!=0.
  - Wraps from 2**CNT_W-1 to 0 with no sticky overflow.
  - Registered output: the value updates one edge after the write is presented.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. If i_WB=1, i_Rw!=0 and i_Rw==i_Ra, then o_busA=i_data in the same cycle; likewise for port B.
  - o_busy_a/o_busy_b are forced to 0 when the same-cycle write-back targets that index.
- Not defined:
  - Reads return the stored value; the new data is visible from the cycle after the edge.
  - Busy reflects the pending bit unmodified until the clearing edge.

Test Plan:
- Reset then read: assert i_rst for 2 cycles, then read Ra=5, Rb=31 -> o_busA=0, o_busB=0, busy both 0, o_wb_count=0.
- Write then read: i_WB=1, i_Rw=3, i_data=32'hDEADBEEF for one cycle; read Ra=3.
  - Next cycle -> o_busA=32'hDEADBEEF, o_wb_count=1.
  - Same cycle, with REGFILE_BYPASS_EN -> 32'hDEADBEEF; without it -> 0.
- Register 0 guard: i_WB=1, i_Rw=0, i_data=32'hFFFFFFFF; i_issue=1, i_issue_Rw=0 -> Ra=0 reads 0, o_busy_a=0, o_wb_count unchanged.
- Scoreboard: issue Rw=7, then 3 idle cycles, then WB Rw=7 with Ra=7.
  - o_busy_a=1 for 4 cycles, 0 after the WB edge.
  - With REGFILE_BYPASS_EN, busy drops to 0 already in the WB cycle.
- Simultaneous set/clear: pending[9]=1; same cycle i_WB with Rw=9 and i_issue with Rw=9 -> pending[9] stays 1 and reg[9] is updated.
- Counter wrap and reset mid-run: CNT_W=4, perform 17 writes -> o_wb_count=1; then assert i_rst with i_WB=1 in the same cycle -> o_wb_count=0 and the target register stays 0.

Source files
------------

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: register file, RAW scoreboard and retired-write counter.
// Optional REGFILE_BYPASS_EN adds same-cycle write-through on both read ports.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_WB,
  input  logic [ADDR_W-1:0] i_Rw,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_Ra,
  input  logic [ADDR_W-1:0] i_Rb,
  output logic [DATA_W-1:0] o_busA,
  output logic [DATA_W-1:0] o_busB,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_issue_Rw,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic [CNT_W-1:0]  o_wb_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we, iss;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign we  = i_WB && (i_Rw != '0);
  assign iss = i_issue && (i_issue_Rw != '0);

  // Set is applied after clear so a re-issue wins over its predecessor's write-back.
  always_comb begin
    pend_d = pend_q;
    if (we)  pend_d[i_Rw] = 1'b0;
    if (iss) pend_d[i_issue_Rw] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (we) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we) rf_q[i_Rw] <= i_data;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_a = (i_Ra == '0) ? '0 : rf_q[i_Ra];
  assign rd_b = (i_Rb == '0) ? '0 : rf_q[i_Rb];

`ifdef REGFILE_BYPASS_EN
  logic byp_a, byp_b;
  assign byp_a    = we && (i_Rw == i_Ra);
  assign byp_b    = we && (i_Rw == i_Rb);
  assign o_busA   = byp_a ? i_data : rd_a;
  assign o_busB   = byp_b ? i_data : rd_b;
  assign o_busy_a = pend_q[i_Ra] & ~byp_a;
  assign o_busy_b = pend_q[i_Rb] & ~byp_b;
`else
  assign o_busA   = rd_a;
  assign o_busB   = rd_b;
  assign o_busy_a = pend_q[i_Ra];
  assign o_busy_b = pend_q[i_Rb];
`endif

  assign o_wb_count = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: driver pushes expectations,
// a monitor pops and compares just before each rising edge.
module tb_writeback_regfile;

  localparam int CW = 4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_WB, i_issue;
  logic [4:0]  i_Rw, i_Ra, i_Rb, i_issue_Rw;
  logic [31:0] i_data, o_busA, o_busB;
  logic        o_busy_a, o_busy_b;
  logic [CW-1:0] o_wb_count;

  writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_WB(i_WB), .i_Rw(i_Rw),
    .i_data(i_data), .i_Ra(i_Ra), .i_Rb(i_Rb),
    .o_busA(o_busA), .o_busB(o_busB),
    .i_issue(i_issue), .i_issue_Rw(i_issue_Rw),
    .o_busy_a(o_busy_a), .o_busy_b(o_busy_b),
    .o_wb_count(o_wb_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a, b;
    logic        ba, bb;
    logic [CW-1:0] c;
    string       tag;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  bit [31:0] mem [32];
  bit        pend [32];
  int        cnt = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit wb, input bit [4:0] rw,
                     input bit [31:0] d, input bit [4:0] ra,
                     input bit [4:0] rb, input bit iss,
                     input bit [4:0] irw, input bit check = 1'b1,
                     input string tag = "rnd");
    exp_t e;
    bit fa, fb;
    @(negedge i_clk);
    i_rst = rst; i_WB = wb; i_Rw = rw; i_data = d;
    i_Ra = ra; i_Rb = rb; i_issue = iss; i_issue_Rw = irw;
    fa = BYP && wb && rw != 0 && rw == ra;
    fb = BYP && wb && rw != 0 && rw == rb;
    e.a  = (ra == 0) ? 32'd0 : (fa ? d : mem[ra]);
    e.b  = (rb == 0) ? 32'd0 : (fb ? d : mem[rb]);
    e.ba = (ra != 0) && pend[ra] && !fa;
    e.bb = (rb != 0) && pend[rb] && !fb;
    e.c  = CW'(cnt);
    e.tag = tag;
    if (check) q.push_back(e);
    if (rst) begin
      foreach (mem[i]) begin mem[i] = 0; pend[i] = 0; end
      cnt = 0;
    end else begin
      if (wb && rw != 0) begin
        mem[rw] = d;
        pend[rw] = 0;
        cnt = (cnt + 1) % (1 << CW);
      end
      if (iss && irw != 0) pend[irw] = 1;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".busA"}, o_busA, e.a);
        chk({e.tag, ".busB"}, o_busB, e.b);
        chk({e.tag, ".busy_a"}, {31'd0, o_busy_a}, {31'd0, e.ba});
        chk({e.tag, ".busy_b"}, {31'd0, o_busy_b}, {31'd0, e.bb});
        chk({e.tag, ".count"}, {28'd0, o_wb_count}, {28'd0, e.c});
      end
    end
  end

  initial begin
    i_rst = 1; i_WB = 0; i_Rw = 0; i_data = 0; i_Ra = 0; i_Rb = 0;
    i_issue = 0; i_issue_Rw = 0;
    cyc(1, 0, 0, 0, 5, 31, 0, 0, 1'b0);
    cyc(1, 0, 0, 0, 5, 31, 0, 0, 1'b1, "rst");
    cyc(0, 0, 0, 0, 5, 31, 0, 0, 1'b1, "rst_read");
    cyc(0, 1, 3, 32'hDEADBEEF, 3, 0, 0, 0, 1'b1, "wr_same");
    cyc(0, 0, 0, 0, 3, 3, 0, 0, 1'b1, "wr_next");
    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 1'b1, "r0_guard");
    cyc(0, 0, 0, 0, 0, 3, 0, 0, 1'b1, "r0_after");
    cyc(0, 0, 0, 0, 7, 7, 1, 7, 1'b1, "sb_issue");
    repeat (3) cyc(0, 0, 0, 0, 7, 0, 0, 0, 1'b1, "sb_idle");
    cyc(0, 1, 7, 32'h1234_5678, 7, 7, 0, 0, 1'b1, "sb_wb");
    cyc(0, 0, 0, 0, 7, 7, 0, 0, 1'b1, "sb_after");
    cyc(0, 0, 0, 0, 9, 0, 1, 9, 1'b1, "ss_set");
    cyc(0, 1, 9, 32'hCAFE_F00D, 9, 9, 1, 9, 1'b1, "ss_both");
    cyc(0, 0, 0, 0, 9, 9, 0, 0, 1'b1, "ss_after");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1'b1, "rst2");
    for (int i = 0; i < 17; i++)
      cyc(0, 1, 5'(1 + i % 31), 32'(i * 7 + 1), 5'(1 + i % 31), 1, 0, 0,
          1'b1, "wrap");
    cyc(0, 0, 0, 0, 1, 2, 0, 0, 1'b1, "wrap_cnt");
    cyc(0, 0, 0, 0, 0, 0, 1, 12, 1'b1, "mid_iss");
    cyc(1, 1, 12, 32'hAAAA_5555, 12, 12, 1, 12, 1'b1, "rst_wb");
    cyc(0, 0, 0, 0, 12, 1, 0, 0, 1'b1, "rst_wb_after");
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    @(negedge i_clk);
    i_WB = 0; i_issue = 0; i_rst = 0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge i_clk);
    #6;
    if (q.size() > 0) begin
      fails++;
      tests++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
